// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared constants for the PC / instruction-fetch sequencer: state encodings,
// instruction size and the default address width.
package pc_fetch_sequencer_pkg;

  localparam int ADDR_W_DEF  = 64;
  localparam int INSTR_BYTES = 4;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_HOLD   = 2'd2;
  localparam logic [1:0] S_HALTED = 2'd3;

endpackage

// File: rtl/pc_fetch_sequencer_pc_reg_inc.sv
// Program-counter register with its sequential +INSTR_BYTES adder; the sum
// wraps modulo 2**ADDR_W.
module pc_reg_inc
  import pc_fetch_sequencer_pkg::*;
#(
  parameter int               ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              CLK,
  input  logic              Reset_L,
  input  logic              loadEn,
  input  logic [ADDR_W-1:0] loadVal,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4
);

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      pc <= RESET_PC;
    end else if (loadEn) begin
      pc <= loadVal;
    end
  end

  assign pc_plus4 = pc + ADDR_W'(INSTR_BYTES);

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Fetch stage: holds the PC, fetches over a req/ack memory port and hands each
// instruction to decode over valid/ready, feeding pc_plus4 back to the PC mux.
module pc_fetch_sequencer
  import pc_fetch_sequencer_pkg::*;
#(
  parameter int               ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int               CNT_W    = 16
) (
  input  logic              CLK,
  input  logic              Reset_L,
  input  logic [ADDR_W-1:0] next_pc,
  input  logic              halt,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              misalign,
  output logic [CNT_W-1:0]  fetch_count,
  output logic              halted
);

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pcAligned;
  logic              accept;

  // The PC only moves on the decode handshake; low bits are forced to a word boundary.
  assign accept    = (state == S_HOLD) && instr_valid && instr_ready;
  assign pcAligned = {next_pc[ADDR_W-1:2], 2'b00};

  pc_reg_inc #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RESET_PC)
  ) uPcReg (
    .CLK     (CLK),
    .Reset_L (Reset_L),
    .loadEn  (accept),
    .loadVal (pcAligned),
    .pc      (pc),
    .pc_plus4(pc_plus4)
  );

  assign imem_addr = pc;
  assign halted    = (state == S_HALTED);

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state       <= S_IDLE;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      fetch_count <= '0;
      misalign    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (halt) begin
            state <= S_HALTED;
          end else begin
            state    <= S_FETCH;
            imem_req <= 1'b1;
          end
        end
        S_FETCH: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= S_HOLD;
          end
        end
        S_HOLD: begin
          // halt is only honoured once the held instruction has been taken.
          if (instr_ready) begin
            instr_valid <= 1'b0;
            fetch_count <= fetch_count + CNT_W'(1);
            misalign    <= misalign | (|next_pc[1:0]);
            if (halt) begin
              state <= S_HALTED;
            end else begin
              state    <= S_FETCH;
              imem_req <= 1'b1;
            end
          end
        end
        default: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer: inputs change and outputs are
// sampled on the falling clock edge.
module tb_pc_fetch_sequencer;

  localparam int ADDR_W = 64;
  localparam int CNT_W  = 4;
  localparam logic [ADDR_W-1:0] RPC = 64'h100;

  logic              CLK;
  logic              Reset_L;
  logic [ADDR_W-1:0] next_pc;
  logic              halt;
  logic [ADDR_W-1:0] pc_plus4;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              misalign;
  logic [CNT_W-1:0]  fetch_count;
  logic              halted;

  int vecs;
  int errs;

  pc_fetch_sequencer #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RPC),
    .CNT_W   (CNT_W)
  ) dut (
    .CLK        (CLK),
    .Reset_L    (Reset_L),
    .next_pc    (next_pc),
    .halt       (halt),
    .pc_plus4   (pc_plus4),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .misalign   (misalign),
    .fetch_count(fetch_count),
    .halted     (halted)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic test_reset();
    tick();
    vecs++; if (imem_req !== 1'b0) begin errs++; $display("FAIL rst_req got %0b exp 0", imem_req); end
    vecs++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL rst_valid got %0b exp 0", instr_valid); end
    vecs++; if (instr !== 32'h0) begin errs++; $display("FAIL rst_instr got %h exp 0", instr); end
    vecs++; if (instr_pc !== 64'h0) begin errs++; $display("FAIL rst_instr_pc got %h exp 0", instr_pc); end
    vecs++; if (fetch_count !== 4'd0) begin errs++; $display("FAIL rst_count got %0d exp 0", fetch_count); end
    vecs++; if (misalign !== 1'b0) begin errs++; $display("FAIL rst_misalign got %0b exp 0", misalign); end
    vecs++; if (halted !== 1'b0) begin errs++; $display("FAIL rst_halted got %0b exp 0", halted); end
    vecs++; if (imem_addr !== 64'h100) begin errs++; $display("FAIL rst_pc got %h exp 100", imem_addr); end
  endtask

  task automatic test_startup();
    Reset_L = 1'b1;
    vecs++; if (imem_req !== 1'b0) begin errs++; $display("FAIL idle_req got %0b exp 0", imem_req); end
    tick();
    vecs++; if (imem_req !== 1'b1) begin errs++; $display("FAIL start_req got %0b exp 1", imem_req); end
    vecs++; if (imem_addr !== 64'h100) begin errs++; $display("FAIL start_addr got %h exp 100", imem_addr); end
    vecs++; if (pc_plus4 !== 64'h104) begin errs++; $display("FAIL start_plus4 got %h exp 104", pc_plus4); end
  endtask

  task automatic test_zero_wait();
    logic [ADDR_W-1:0] p;
    logic [31:0]       d;
    imem_ack    = 1'b1;
    instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      p = 64'h100 + 64'(4 * i);
      d = 32'h8B0203E1 + 32'(i);
      vecs++; if (imem_req !== 1'b1) begin errs++; $display("FAIL zw_req[%0d] got %0b exp 1", i, imem_req); end
      vecs++; if (imem_addr !== p) begin errs++; $display("FAIL zw_addr[%0d] got %h exp %h", i, imem_addr, p); end
      vecs++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL zw_gap[%0d] got %0b exp 0", i, instr_valid); end
      imem_rdata = d;
      next_pc    = p + 64'h4;
      tick();
      vecs++; if (instr_valid !== 1'b1) begin errs++; $display("FAIL zw_valid[%0d] got %0b exp 1", i, instr_valid); end
      vecs++; if (instr_pc !== p) begin errs++; $display("FAIL zw_instr_pc[%0d] got %h exp %h", i, instr_pc, p); end
      vecs++; if (instr !== d) begin errs++; $display("FAIL zw_instr[%0d] got %h exp %h", i, instr, d); end
      vecs++; if (imem_req !== 1'b0) begin errs++; $display("FAIL zw_req_drop[%0d] got %0b exp 0", i, imem_req); end
      tick();
    end
    vecs++; if (fetch_count !== 4'd3) begin errs++; $display("FAIL zw_count got %0d exp 3", fetch_count); end
    vecs++; if (imem_addr !== 64'h10C) begin errs++; $display("FAIL zw_next_addr got %h exp 10c", imem_addr); end
  endtask

  task automatic test_backpressure();
    imem_ack    = 1'b0;
    instr_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      vecs++; if (imem_req !== 1'b1) begin errs++; $display("FAIL bp_req[%0d] got %0b exp 1", j, imem_req); end
      vecs++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL bp_wait_valid[%0d] got %0b exp 0", j, instr_valid); end
      vecs++; if (imem_addr !== 64'h10C) begin errs++; $display("FAIL bp_wait_addr[%0d] got %h exp 10c", j, imem_addr); end
      if (j == 3) begin
        imem_ack   = 1'b1;
        imem_rdata = 32'h12345678;
      end
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      vecs++; if (instr_valid !== 1'b1) begin errs++; $display("FAIL bp_valid[%0d] got %0b exp 1", k, instr_valid); end
      vecs++; if (instr !== 32'h12345678) begin errs++; $display("FAIL bp_instr[%0d] got %h exp 12345678", k, instr); end
      vecs++; if (instr_pc !== 64'h10C) begin errs++; $display("FAIL bp_instr_pc[%0d] got %h exp 10c", k, instr_pc); end
      vecs++; if (imem_addr !== 64'h10C) begin errs++; $display("FAIL bp_pc[%0d] got %h exp 10c", k, imem_addr); end
      vecs++; if (imem_req !== 1'b0) begin errs++; $display("FAIL bp_hold_req[%0d] got %0b exp 0", k, imem_req); end
      vecs++; if (fetch_count !== 4'd3) begin errs++; $display("FAIL bp_count[%0d] got %0d exp 3", k, fetch_count); end
      imem_ack   = 1'b1;
      imem_rdata = 32'hA5A50000 + 32'(k);
      next_pc    = 64'hDEAD_0000 + 64'(k);
      if (k == 3) begin
        instr_ready = 1'b1;
        next_pc     = 64'h110;
        imem_ack    = 1'b0;
      end
      tick();
    end
    vecs++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL bp_release_valid got %0b exp 0", instr_valid); end
    vecs++; if (imem_req !== 1'b1) begin errs++; $display("FAIL bp_release_req got %0b exp 1", imem_req); end
    vecs++; if (imem_addr !== 64'h110) begin errs++; $display("FAIL bp_release_addr got %h exp 110", imem_addr); end
    vecs++; if (fetch_count !== 4'd4) begin errs++; $display("FAIL bp_release_count got %0d exp 4", fetch_count); end
  endtask

  task automatic test_branch_misalign();
    vecs++; if (misalign !== 1'b0) begin errs++; $display("FAIL br_pre_misalign got %0b exp 0", misalign); end
    imem_ack    = 1'b1;
    instr_ready = 1'b1;
    imem_rdata  = 32'h00000013;
    next_pc     = 64'h2006;
    tick(); tick();
    vecs++; if (imem_addr !== 64'h2004) begin errs++; $display("FAIL br_addr got %h exp 2004", imem_addr); end
    vecs++; if (misalign !== 1'b1) begin errs++; $display("FAIL br_misalign got %0b exp 1", misalign); end
    vecs++; if (fetch_count !== 4'd5) begin errs++; $display("FAIL br_count got %0d exp 5", fetch_count); end
    next_pc = 64'h2008;
    tick(); tick();
    vecs++; if (imem_addr !== 64'h2008) begin errs++; $display("FAIL br_aligned_addr got %h exp 2008", imem_addr); end
    vecs++; if (misalign !== 1'b1) begin errs++; $display("FAIL br_sticky got %0b exp 1", misalign); end
    next_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    tick(); tick();
    vecs++; if (imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin errs++; $display("FAIL wrap_addr got %h exp fffffffffffffffc", imem_addr); end
    vecs++; if (pc_plus4 !== 64'h0) begin errs++; $display("FAIL wrap_plus4 got %h exp 0", pc_plus4); end
    next_pc = 64'h300;
    tick(); tick();
    vecs++; if (imem_addr !== 64'h300) begin errs++; $display("FAIL br_back_addr got %h exp 300", imem_addr); end
    vecs++; if (fetch_count !== 4'd8) begin errs++; $display("FAIL br_back_count got %0d exp 8", fetch_count); end
    vecs++; if (misalign !== 1'b1) begin errs++; $display("FAIL br_sticky2 got %0b exp 1", misalign); end
  endtask

  task automatic test_halt();
    imem_ack    = 1'b0;
    halt        = 1'b1;
    instr_ready = 1'b1;
    next_pc     = 64'h304;
    tick();
    vecs++; if (imem_req !== 1'b1) begin errs++; $display("FAIL halt_fetch_req got %0b exp 1", imem_req); end
    vecs++; if (halted !== 1'b0) begin errs++; $display("FAIL halt_early got %0b exp 0", halted); end
    imem_ack   = 1'b1;
    imem_rdata = 32'hCAFEF00D;
    tick();
    vecs++; if (instr_valid !== 1'b1) begin errs++; $display("FAIL halt_deliver got %0b exp 1", instr_valid); end
    vecs++; if (instr !== 32'hCAFEF00D) begin errs++; $display("FAIL halt_instr got %h exp cafef00d", instr); end
    vecs++; if (instr_pc !== 64'h300) begin errs++; $display("FAIL halt_instr_pc got %h exp 300", instr_pc); end
    imem_ack = 1'b0;
    tick();
    vecs++; if (halted !== 1'b1) begin errs++; $display("FAIL halt_state got %0b exp 1", halted); end
    vecs++; if (fetch_count !== 4'd9) begin errs++; $display("FAIL halt_count got %0d exp 9", fetch_count); end
    halt = 1'b0;
    for (int k = 0; k < 4; k++) begin
      imem_ack   = k[0];
      next_pc    = 64'h4000 + 64'(k);
      tick();
      vecs++; if (halted !== 1'b1) begin errs++; $display("FAIL halted_hold[%0d] got %0b exp 1", k, halted); end
      vecs++; if (imem_req !== 1'b0) begin errs++; $display("FAIL halted_req[%0d] got %0b exp 0", k, imem_req); end
      vecs++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL halted_valid[%0d] got %0b exp 0", k, instr_valid); end
      vecs++; if (fetch_count !== 4'd9) begin errs++; $display("FAIL halted_count[%0d] got %0d exp 9", k, fetch_count); end
      vecs++; if (imem_addr !== 64'h304) begin errs++; $display("FAIL halted_pc[%0d] got %h exp 304", k, imem_addr); end
    end
  endtask

  task automatic test_reset_mid_hold();
    Reset_L = 1'b0;
    #1;
    vecs++; if (halted !== 1'b0) begin errs++; $display("FAIL rst_halted_clear got %0b exp 0", halted); end
    tick();
    Reset_L     = 1'b1;
    halt        = 1'b0;
    imem_ack    = 1'b1;
    instr_ready = 1'b0;
    imem_rdata  = 32'h55AA55AA;
    tick(); tick();
    vecs++; if (instr_valid !== 1'b1) begin errs++; $display("FAIL mh_valid got %0b exp 1", instr_valid); end
    vecs++; if (instr !== 32'h55AA55AA) begin errs++; $display("FAIL mh_instr got %h exp 55aa55aa", instr); end
    #2;
    Reset_L = 1'b0;
    #1;
    vecs++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL mh_rst_valid got %0b exp 0", instr_valid); end
    vecs++; if (imem_addr !== 64'h100) begin errs++; $display("FAIL mh_rst_pc got %h exp 100", imem_addr); end
    vecs++; if (instr !== 32'h0) begin errs++; $display("FAIL mh_rst_instr got %h exp 0", instr); end
    vecs++; if (misalign !== 1'b0) begin errs++; $display("FAIL mh_rst_misalign got %0b exp 0", misalign); end
    vecs++; if (imem_req !== 1'b0) begin errs++; $display("FAIL mh_rst_req got %0b exp 0", imem_req); end
  endtask

  task automatic test_halt_in_idle();
    halt = 1'b1;
    tick();
    Reset_L = 1'b1;
    tick();
    vecs++; if (halted !== 1'b1) begin errs++; $display("FAIL idle_halt got %0b exp 1", halted); end
    vecs++; if (imem_req !== 1'b0) begin errs++; $display("FAIL idle_halt_req got %0b exp 0", imem_req); end
    Reset_L = 1'b0;
    halt    = 1'b0;
  endtask

  task automatic test_count_wrap();
    tick();
    Reset_L     = 1'b1;
    imem_ack    = 1'b1;
    instr_ready = 1'b1;
    tick();
    for (int n = 1; n <= 16; n++) begin
      next_pc = 64'h100 + 64'(4 * n);
      tick(); tick();
      vecs++; if (fetch_count !== CNT_W'(n)) begin errs++; $display("FAIL wrap_count[%0d] got %0d exp %0d", n, fetch_count, n % 16); end
    end
    vecs++; if (fetch_count !== 4'd0) begin errs++; $display("FAIL wrap_final got %0d exp 0", fetch_count); end
  endtask

  initial begin
    vecs        = 0;
    errs        = 0;
    Reset_L     = 1'b0;
    next_pc     = '0;
    halt        = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = '0;
    instr_ready = 1'b0;
    test_reset();
    test_startup();
    test_zero_wait();
    test_backpressure();
    test_branch_misalign();
    test_halt();
    test_reset_mid_hold();
    test_halt_in_idle();
    test_count_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
